// File: rtl/dbus_mem_arbiter.sv
// ============================================================================
// Module  : dbus_mem_arbiter
// Purpose : Two-master arbiter for the data-side memory/MMIO port. Round-robin
//           command grant and in-order read-response routing via an owner FIFO.
//           Optional macro DBUS_ARB_FIXED_PRIO_EN: m0 always wins contention.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dbus_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              m0_cmd_valid,
    output logic              m0_cmd_ready,
    input  logic              m0_cmd_wr,
    input  logic [ADDR_W-1:0] m0_cmd_address,
    input  logic [DATA_W-1:0] m0_cmd_data,
    input  logic [1:0]        m0_cmd_size,
    output logic              m0_rsp_valid,
    output logic [DATA_W-1:0] m0_rsp_data,

    input  logic              m1_cmd_valid,
    output logic              m1_cmd_ready,
    input  logic              m1_cmd_wr,
    input  logic [ADDR_W-1:0] m1_cmd_address,
    input  logic [DATA_W-1:0] m1_cmd_data,
    input  logic [1:0]        m1_cmd_size,
    output logic              m1_rsp_valid,
    output logic [DATA_W-1:0] m1_rsp_data,

    output logic              s_cmd_valid,
    input  logic              s_cmd_ready,
    output logic              s_cmd_wr,
    output logic [ADDR_W-1:0] s_cmd_address,
    output logic [DATA_W-1:0] s_cmd_data,
    output logic [1:0]        s_cmd_size,
    input  logic              s_rsp_valid,
    input  logic [DATA_W-1:0] s_rsp_data,

    output logic              err_unexp_rsp
);

    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(OUTSTANDING);
    localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(OUTSTANDING - 1);

    // Owner FIFO: one bit per outstanding read, holding the issuing master id
    logic [OUTSTANDING-1:0] r_owner;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_hold;
    logic                   r_hold_id;
    logic                   r_err;

    logic                   w_empty;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_full;
    logic                   w_grant;
    logic                   w_gnt_valid;
    logic                   w_gnt_wr;
    logic                   w_accept;
    logic                   w_head;

    assign w_empty = (r_count == '0);
    assign w_pop   = s_rsp_valid & ~w_empty;
    // A response in the same cycle frees its slot for a new read
    assign w_full  = (r_count == C_DEPTH) & ~w_pop;

`ifdef DBUS_ARB_FIXED_PRIO_EN
    always_comb begin
        w_grant = 1'b0;
        if (r_hold) begin
            w_grant = r_hold_id;
        end else if (m1_cmd_valid && !m0_cmd_valid) begin
            w_grant = 1'b1;
        end
    end
`else
    logic r_rr_last;

    always_comb begin
        w_grant = 1'b0;
        if (r_hold) begin
            w_grant = r_hold_id;
        end else if (m0_cmd_valid && !m1_cmd_valid) begin
            w_grant = 1'b0;
        end else if (m1_cmd_valid && !m0_cmd_valid) begin
            w_grant = 1'b1;
        end else begin
            w_grant = ~r_rr_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rr_last <= 1'b1;
        end else if (w_accept) begin
            r_rr_last <= w_grant;
        end
    end
`endif

    assign w_gnt_valid   = w_grant ? m1_cmd_valid   : m0_cmd_valid;
    assign w_gnt_wr      = w_grant ? m1_cmd_wr      : m0_cmd_wr;
    assign s_cmd_wr      = w_gnt_wr;
    assign s_cmd_address = w_grant ? m1_cmd_address : m0_cmd_address;
    assign s_cmd_data    = w_grant ? m1_cmd_data    : m0_cmd_data;
    assign s_cmd_size    = w_grant ? m1_cmd_size    : m0_cmd_size;
    assign s_cmd_valid   = w_gnt_valid & (w_gnt_wr | ~w_full);

    assign m0_cmd_ready  = ~w_grant & s_cmd_ready & (m0_cmd_wr | ~w_full);
    assign m1_cmd_ready  =  w_grant & s_cmd_ready & (m1_cmd_wr | ~w_full);

    assign w_accept      = s_cmd_valid & s_cmd_ready;
    assign w_push        = w_accept & ~w_gnt_wr;

    assign w_head        = r_owner[r_rd_ptr];
    assign m0_rsp_valid  = w_pop & ~w_head;
    assign m1_rsp_valid  = w_pop &  w_head;
    assign m0_rsp_data   = s_rsp_data;
    assign m1_rsp_data   = s_rsp_data;
    assign err_unexp_rsp = r_err;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_owner   <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_hold    <= 1'b0;
            r_hold_id <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_push) begin
                r_owner[r_wr_ptr] <= w_grant;
                r_wr_ptr          <= (r_wr_ptr == C_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Lock the grant while a presented command waits, so the slave never sees its payload swapped
            r_hold <= w_gnt_valid & ~w_accept;
            if (w_gnt_valid && !w_accept) begin
                r_hold_id <= w_grant;
            end
            if (s_rsp_valid && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dbus_mem_arbiter.sv
// ============================================================================
// Module  : tb_dbus_mem_arbiter
// Purpose : Self-checking bench for dbus_mem_arbiter with directed scenarios
//           and randomized traffic against a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dbus_mem_arbiter;

    localparam int OUT = 2;

    logic        clk;
    logic        reset_n;
    logic        m0_cmd_valid, m0_cmd_ready, m0_cmd_wr, m0_rsp_valid;
    logic [31:0] m0_cmd_address, m0_cmd_data, m0_rsp_data;
    logic [1:0]  m0_cmd_size;
    logic        m1_cmd_valid, m1_cmd_ready, m1_cmd_wr, m1_rsp_valid;
    logic [31:0] m1_cmd_address, m1_cmd_data, m1_rsp_data;
    logic [1:0]  m1_cmd_size;
    logic        s_cmd_valid, s_cmd_ready, s_cmd_wr, s_rsp_valid;
    logic [31:0] s_cmd_address, s_cmd_data, s_rsp_data;
    logic [1:0]  s_cmd_size;
    logic        err_unexp_rsp;

    logic [1:0]  rdy;
    logic [1:0]  rspv;
    assign rdy  = {m1_cmd_ready, m0_cmd_ready};
    assign rspv = {m1_rsp_valid, m0_rsp_valid};

    int n_vec = 0;
    int n_err = 0;

    dbus_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .OUTSTANDING(OUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_wr(m0_cmd_wr),
        .m0_cmd_address(m0_cmd_address), .m0_cmd_data(m0_cmd_data), .m0_cmd_size(m0_cmd_size),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_data(m0_rsp_data),
        .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_wr(m1_cmd_wr),
        .m1_cmd_address(m1_cmd_address), .m1_cmd_data(m1_cmd_data), .m1_cmd_size(m1_cmd_size),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_data(m1_rsp_data),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_wr(s_cmd_wr),
        .s_cmd_address(s_cmd_address), .s_cmd_data(s_cmd_data), .s_cmd_size(s_cmd_size),
        .s_rsp_valid(s_rsp_valid), .s_rsp_data(s_rsp_data),
        .err_unexp_rsp(err_unexp_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        m0_cmd_valid = 0; m0_cmd_wr = 0; m0_cmd_address = 0; m0_cmd_data = 0; m0_cmd_size = 0;
        m1_cmd_valid = 0; m1_cmd_wr = 0; m1_cmd_address = 0; m1_cmd_data = 0; m1_cmd_size = 0;
        s_cmd_ready  = 1; s_rsp_valid = 0; s_rsp_data = 0;
    endtask

    task automatic do_reset;
        reset_n = 0;
        idle_inputs();
        step();
        step();
        reset_n = 1;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        n_vec++; if (s_cmd_valid !== 1'b0) begin n_err++; $display("FAIL reset_s_cmd_valid got=%b exp=0", s_cmd_valid); end
        n_vec++; if (rspv !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=00", rspv); end
        n_vec++; if (err_unexp_rsp !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", err_unexp_rsp); end
        n_vec++; if (rdy !== 2'b01) begin n_err++; $display("FAIL reset_ready got=%b exp=01", rdy); end
    endtask

    task automatic test_single_read;
        do_reset();
        m0_cmd_valid = 1; m0_cmd_wr = 0; m0_cmd_address = 32'h10; m0_cmd_size = 2;
        #1;
        n_vec++; if (s_cmd_valid !== 1'b1) begin n_err++; $display("FAIL single_s_valid got=%b exp=1", s_cmd_valid); end
        n_vec++; if (s_cmd_address !== 32'h10) begin n_err++; $display("FAIL single_addr got=%h exp=00000010", s_cmd_address); end
        n_vec++; if (rspv !== 2'b00) begin n_err++; $display("FAIL single_early_rsp got=%b exp=00", rspv); end
        step();
        m0_cmd_valid = 0; s_rsp_valid = 1; s_rsp_data = 32'hCAFE_0010;
        #1;
        n_vec++; if (rspv !== 2'b01) begin n_err++; $display("FAIL single_rsp_route got=%b exp=01", rspv); end
        n_vec++; if (m0_rsp_data !== 32'hCAFE_0010) begin n_err++; $display("FAIL single_rsp_data got=%h exp=cafe0010", m0_rsp_data); end
        step();
        s_rsp_valid = 0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] a [2][4];
        int q[$];
        int rem[2];
        int k, exp_id, o;
        bit rp;
        logic [31:0] rd;
        do_reset();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 4; j++) a[i][j] = $urandom & 32'h7FFF_FFFC;
        rem = '{4, 4}; k = 0; rp = 0;
        for (int c = 0; c < 30 && (k < 8 || rp); c++) begin
            m0_cmd_valid = (rem[0] > 0); m0_cmd_wr = 0; m0_cmd_address = (rem[0] > 0) ? a[0][4-rem[0]] : 32'h0;
            m1_cmd_valid = (rem[1] > 0); m1_cmd_wr = 0; m1_cmd_address = (rem[1] > 0) ? a[1][4-rem[1]] : 32'h0;
            rd = $urandom; s_rsp_valid = rp; s_rsp_data = rd;
            #1;
            if (rp) begin
                o = q.pop_front();
                n_vec++; if (rspv !== (2'b01 << o)) begin n_err++; $display("FAIL b2b_rsp_route got=%b exp_owner=%0d", rspv, o); end
                rp = 0;
            end
            if (k < 8) begin
`ifdef DBUS_ARB_FIXED_PRIO_EN
                exp_id = (k < 4) ? 0 : 1;
`else
                exp_id = k % 2;
`endif
                n_vec++; if (rdy !== (2'b01 << exp_id)) begin n_err++; $display("FAIL b2b_grant got_ready=%b exp_master=%0d", rdy, exp_id); end
                n_vec++; if (s_cmd_address !== a[exp_id][4-rem[exp_id]]) begin n_err++; $display("FAIL b2b_addr got=%h exp=%h", s_cmd_address, a[exp_id][4-rem[exp_id]]); end
                q.push_back(exp_id); rem[exp_id]--; k++; rp = 1;
            end
            step();
        end
        n_vec++; if (k != 8 || rp) begin n_err++; $display("FAIL b2b_timeout got=%0d exp=8", k); end
        idle_inputs();
    endtask

    task automatic test_full_stall;
        do_reset();
        m1_cmd_valid = 1; m1_cmd_wr = 0; m1_cmd_size = 2; m1_cmd_address = 32'h100;
        #1;
        n_vec++; if (m1_cmd_ready !== 1'b1) begin n_err++; $display("FAIL full_rd1_ready got=%b exp=1", m1_cmd_ready); end
        step();
        m1_cmd_address = 32'h104;
        #1;
        n_vec++; if (m1_cmd_ready !== 1'b1) begin n_err++; $display("FAIL full_rd2_ready got=%b exp=1", m1_cmd_ready); end
        step();
        m1_cmd_address = 32'h108;
        #1;
        n_vec++; if (m1_cmd_ready !== 1'b0) begin n_err++; $display("FAIL full_rd3_ready got=%b exp=0", m1_cmd_ready); end
        n_vec++; if (s_cmd_valid !== 1'b0) begin n_err++; $display("FAIL full_rd3_svalid got=%b exp=0", s_cmd_valid); end
        step();
        m1_cmd_wr = 1; m1_cmd_address = 32'h8000_0000; m1_cmd_data = 32'h5;
        #1;
        n_vec++; if (m1_cmd_ready !== 1'b1) begin n_err++; $display("FAIL full_wr_ready got=%b exp=1", m1_cmd_ready); end
        n_vec++; if ({s_cmd_valid, s_cmd_wr} !== 2'b11) begin n_err++; $display("FAIL full_wr_cmd got=%b exp=11", {s_cmd_valid, s_cmd_wr}); end
        n_vec++; if (s_cmd_data !== 32'h5) begin n_err++; $display("FAIL full_wr_data got=%h exp=00000005", s_cmd_data); end
        step();
        m1_cmd_wr = 0; m1_cmd_address = 32'h108;
        #1;
        n_vec++; if (m1_cmd_ready !== 1'b0) begin n_err++; $display("FAIL full_still_full got=%b exp=0", m1_cmd_ready); end
        s_rsp_valid = 1; s_rsp_data = 32'h11;
        #1;
        n_vec++; if (m1_cmd_ready !== 1'b1) begin n_err++; $display("FAIL full_pop_push_ready got=%b exp=1", m1_cmd_ready); end
        n_vec++; if (rspv !== 2'b10) begin n_err++; $display("FAIL full_rsp1 got=%b exp=10", rspv); end
        step();
        m1_cmd_valid = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_vec++; if (rspv !== 2'b10) begin n_err++; $display("FAIL full_drain got=%b exp=10", rspv); end
            step();
        end
        s_rsp_valid = 0;
        #1;
        n_vec++; if (err_unexp_rsp !== 1'b0) begin n_err++; $display("FAIL full_err got=%b exp=0", err_unexp_rsp); end
        idle_inputs();
    endtask

    task automatic test_hold;
        do_reset();
        s_cmd_ready = 0;
        m1_cmd_valid = 1; m1_cmd_wr = 0; m1_cmd_address = 32'h200;
        #1;
        n_vec++; if (s_cmd_address !== 32'h200) begin n_err++; $display("FAIL hold_first got=%h exp=00000200", s_cmd_address); end
        step();
        m0_cmd_valid = 1; m0_cmd_wr = 0; m0_cmd_address = 32'h100;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_vec++; if (s_cmd_address !== 32'h200 || m0_cmd_ready !== 1'b0) begin n_err++; $display("FAIL hold_stall got=%h exp=00000200", s_cmd_address); end
            step();
        end
        s_cmd_ready = 1;
        #1;
        n_vec++; if (rdy !== 2'b10) begin n_err++; $display("FAIL hold_release got=%b exp=10", rdy); end
        step();
        m1_cmd_valid = 0;
        #1;
        n_vec++; if (rdy !== 2'b01 || s_cmd_address !== 32'h100) begin n_err++; $display("FAIL hold_next got=%h exp=00000100", s_cmd_address); end
        step();
        m0_cmd_valid = 0; s_rsp_valid = 1;
        #1;
        n_vec++; if (rspv !== 2'b10) begin n_err++; $display("FAIL hold_rsp1 got=%b exp=10", rspv); end
        step();
        #1;
        n_vec++; if (rspv !== 2'b01) begin n_err++; $display("FAIL hold_rsp2 got=%b exp=01", rspv); end
        step();
        idle_inputs();
    endtask

    task automatic test_unexp_rsp;
        do_reset();
        s_rsp_valid = 1;
        #1;
        n_vec++; if (rspv !== 2'b00) begin n_err++; $display("FAIL unexp_routed got=%b exp=00", rspv); end
        step();
        s_rsp_valid = 0;
        step(); step();
        n_vec++; if (err_unexp_rsp !== 1'b1) begin n_err++; $display("FAIL unexp_sticky got=%b exp=1", err_unexp_rsp); end
        reset_n = 0;
        step();
        reset_n = 1;
        n_vec++; if (err_unexp_rsp !== 1'b0) begin n_err++; $display("FAIL unexp_clear got=%b exp=0", err_unexp_rsp); end
        // A read in flight across reset must be forgotten
        m0_cmd_valid = 1; m0_cmd_address = 32'h40;
        step();
        m0_cmd_valid = 0;
        do_reset();
        s_rsp_valid = 1;
        #1;
        n_vec++; if (rspv !== 2'b00) begin n_err++; $display("FAIL unexp_after_reset got=%b exp=00", rspv); end
        step();
        s_rsp_valid = 0;
        n_vec++; if (err_unexp_rsp !== 1'b1) begin n_err++; $display("FAIL unexp_after_reset_err got=%b exp=1", err_unexp_rsp); end
        idle_inputs();
    endtask

    task automatic test_fixed_prio;
        logic [31:0] d[2];
        int exp_id;
        do_reset();
        m0_cmd_valid = 1; m0_cmd_wr = 1; m1_cmd_valid = 1; m1_cmd_wr = 1;
        d[0] = $urandom; d[1] = $urandom;
        for (int c = 0; c < 8; c++) begin
            m0_cmd_data = d[0]; m1_cmd_data = d[1];
            #1;
`ifdef DBUS_ARB_FIXED_PRIO_EN
            exp_id = 0;
`else
            exp_id = c % 2;
`endif
            n_vec++; if (rdy !== (2'b01 << exp_id)) begin n_err++; $display("FAIL prio_grant got=%b exp_master=%0d", rdy, exp_id); end
            n_vec++; if (s_cmd_data !== d[exp_id]) begin n_err++; $display("FAIL prio_data got=%h exp=%h", s_cmd_data, d[exp_id]); end
            d[exp_id] = $urandom;
            step();
        end
        idle_inputs();
    endtask

    task automatic test_random;
        int owner_q[$];
        int due_q[$];
        bit pv[2], pwr[2];
        logic [31:0] pa[2], pd[2];
        logic [1:0] psz[2];
        bit hold, rv, full, ev, acc;
        int hold_id, rr_last, g, occ, last_due, cyc;
        logic [31:0] rd;
        logic [1:0] er, eq;
        do_reset();
        hold = 0; hold_id = 0; rr_last = 1; last_due = 0;
        pv = '{0, 0}; pwr = '{0, 0};
        for (cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pv[i] && $urandom_range(2, 0) != 0) begin
                    pv[i] = 1; pwr[i] = ($urandom_range(2, 0) == 0);
                    pa[i] = $urandom; pd[i] = $urandom; psz[i] = 2'($urandom_range(2, 0));
                end
            end
            m0_cmd_valid = pv[0]; m0_cmd_wr = pwr[0]; m0_cmd_address = pa[0]; m0_cmd_data = pd[0]; m0_cmd_size = psz[0];
            m1_cmd_valid = pv[1]; m1_cmd_wr = pwr[1]; m1_cmd_address = pa[1]; m1_cmd_data = pd[1]; m1_cmd_size = psz[1];
            s_cmd_ready = ($urandom_range(3, 0) != 0);
            rv = (owner_q.size() > 0) && (due_q[0] <= cyc);
            rd = $urandom; s_rsp_valid = rv; s_rsp_data = rd;
            #1;
            if (hold)                 g = hold_id;
            else if (pv[0] && !pv[1]) g = 0;
            else if (pv[1] && !pv[0]) g = 1;
            else begin
`ifdef DBUS_ARB_FIXED_PRIO_EN
                g = 0;
`else
                g = 1 - rr_last;
`endif
            end
            occ  = owner_q.size() - (rv ? 1 : 0);
            full = (occ >= OUT);
            ev   = pv[g] && (pwr[g] || !full);
            er   = 2'b00;
            er[g] = s_cmd_ready && (pwr[g] || !full);
            n_vec++; if (s_cmd_valid !== ev) begin n_err++; $display("FAIL rnd_svalid cyc=%0d got=%b exp=%b", cyc, s_cmd_valid, ev); end
            n_vec++; if (rdy !== er) begin n_err++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, rdy, er); end
            if (ev) begin
                n_vec++;
                if ({s_cmd_wr, s_cmd_size, s_cmd_address, s_cmd_data} !== {pwr[g], psz[g], pa[g], pd[g]}) begin
                    n_err++; $display("FAIL rnd_payload cyc=%0d got=%h exp=%h", cyc, s_cmd_address, pa[g]);
                end
            end
            eq = 2'b00;
            if (rv) eq[owner_q[0]] = 1'b1;
            n_vec++; if (rspv !== eq) begin n_err++; $display("FAIL rnd_rsp_route cyc=%0d got=%b exp=%b", cyc, rspv, eq); end
            if (rv) begin
                n_vec++; if (m0_rsp_data !== rd || m1_rsp_data !== rd) begin n_err++; $display("FAIL rnd_rsp_data cyc=%0d got=%h exp=%h", cyc, m0_rsp_data, rd); end
                void'(owner_q.pop_front()); void'(due_q.pop_front());
            end
            acc = ev && s_cmd_ready;
            if (acc) begin
                if (!pwr[g]) begin
                    last_due = (last_due > cyc + 1) ? last_due : cyc + 1 + $urandom_range(2, 0);
                    owner_q.push_back(g); due_q.push_back(last_due);
                end
                pv[g] = 0; rr_last = g; hold = 0;
            end else begin
                hold = pv[g]; hold_id = g;
            end
            step();
        end
        m0_cmd_valid = 0; m1_cmd_valid = 0;
        for (int c = 0; c < 20 && owner_q.size() > 0; c++) begin
            s_rsp_valid = 1;
            #1;
            eq = 2'b00; eq[owner_q[0]] = 1'b1;
            n_vec++; if (rspv !== eq) begin n_err++; $display("FAIL rnd_drain got=%b exp=%b", rspv, eq); end
            void'(owner_q.pop_front());
            step();
        end
        s_rsp_valid = 0;
        #1;
        n_vec++; if (err_unexp_rsp !== 1'b0) begin n_err++; $display("FAIL rnd_err got=%b exp=0", err_unexp_rsp); end
        idle_inputs();
    endtask

    initial begin
        reset_n = 0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_back_to_back();
        test_full_stall();
        test_hold();
        test_unexp_rsp();
        test_fixed_prio();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
